// File: rtl/instr_encoder_if.sv
// Request/response bus of the RV32I instruction encoder: field-level request in,
// tagged 32-bit instruction word out, each direction with its own valid/ready pair.
interface instr_encoder_if #(
    parameter int unsigned ADDR_WIDTH = 6
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_class;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic                  in_funct7b5;
    logic [31:0]           in_imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH+1:0] out_addr;

    modport master (
        output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction encoder: assembles instruction words from field-level
// requests and emits them through a 2-entry FIFO tagged with sequential byte addresses.
module instr_encoder #(
    parameter int unsigned ADDR_WIDTH    = 6,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instr_encoder_if.slave           bus,
    output logic                     err,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH:0]      emit_count
);
    localparam int unsigned OUT_AW = ADDR_WIDTH + 2;
    localparam int unsigned EMIT_W = ADDR_WIDTH + 1;

    localparam logic [2:0] CLS_LW  = 3'd0;
    localparam logic [2:0] CLS_SW  = 3'd1;
    localparam logic [2:0] CLS_R   = 3'd2;
    localparam logic [2:0] CLS_BEQ = 3'd3;
    localparam logic [2:0] CLS_I   = 3'd4;
    localparam logic [2:0] CLS_JAL = 3'd5;

    logic [31:0] imm;
    logic        fits12_c;
    logic        fits13_c;
    logic        fits21_c;
    logic        is_shift_c;
    logic [31:0] enc_word_c;
    logic        enc_legal_c;
    logic        accept_c;
    logic        push_c;
    logic        pop_c;
    logic [1:0]  count_q;
    logic [1:0]  count_nxt;
    logic [31:0] tail_q;

    assign imm        = bus.in_imm;
    assign fits12_c   = (imm[31:11] == {21{imm[11]}});
    assign fits13_c   = (imm[31:12] == {20{imm[12]}});
    assign fits21_c   = (imm[31:20] == {12{imm[20]}});
    assign is_shift_c = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);

    // Field packing and legality of the request currently presented
    always_comb begin
        enc_word_c  = '0;
        enc_legal_c = 1'b0;
        case (bus.in_class)
            CLS_LW: begin
                enc_word_c  = {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
                enc_legal_c = fits12_c;
            end
            CLS_SW: begin
                enc_word_c  = {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], 7'b0100011};
                enc_legal_c = fits12_c;
            end
            CLS_R: begin
                enc_word_c  = {1'b0, bus.in_funct7b5, 5'b00000, bus.in_rs2, bus.in_rs1,
                               bus.in_funct3, bus.in_rd, 7'b0110011};
                enc_legal_c = 1'b1;
            end
            CLS_BEQ: begin
                enc_word_c  = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                               imm[4:1], imm[11], 7'b1100011};
                enc_legal_c = fits13_c && !imm[0];
            end
            CLS_I: begin
                if (is_shift_c) begin
                    enc_word_c  = {1'b0, bus.in_funct7b5, 5'b00000, imm[4:0], bus.in_rs1,
                                   bus.in_funct3, bus.in_rd, 7'b0010011};
                    enc_legal_c = (imm[31:5] == 27'd0);
                end else begin
                    enc_word_c  = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011};
                    enc_legal_c = fits12_c;
                end
            end
            CLS_JAL: begin
                enc_word_c  = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
                enc_legal_c = fits21_c && !imm[0];
            end
            default: ;
        endcase
    end

    assign accept_c = bus.in_valid && bus.in_ready;
    assign push_c   = accept_c && enc_legal_c;
    assign pop_c    = bus.out_valid && bus.out_ready;

    always_comb begin
        count_nxt = count_q;
        case ({push_c, pop_c})
            2'b10:   count_nxt = count_q + 2'd1;
            2'b01:   count_nxt = count_q - 2'd1;
            default: ;
        endcase
    end

    // out_instr is the FIFO head register; tail_q holds the second entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            tail_q        <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_instr <= '0;
            bus.out_addr  <= '0;
            err           <= 1'b0;
            err_count     <= '0;
            emit_count    <= '0;
        end else begin
            count_q       <= count_nxt;
            bus.in_ready  <= (count_nxt != 2'd2);
            bus.out_valid <= (count_nxt != 2'd0);
            err           <= accept_c && !enc_legal_c;
            if (pop_c) begin
                bus.out_instr <= (push_c && (count_q == 2'd1)) ? enc_word_c : tail_q;
                bus.out_addr  <= bus.out_addr + OUT_AW'(4);
                if (emit_count != '1) begin
                    emit_count <= emit_count + EMIT_W'(1);
                end
            end else if (push_c) begin
                if (count_q == 2'd0) begin
                    bus.out_instr <= enc_word_c;
                end else begin
                    tail_q <= enc_word_c;
                end
            end
            if (accept_c && !enc_legal_c && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected words/addresses, checked as
// the DUT pops them; second small-address instance exercises address wrap.
module tb_instr_encoder;
    localparam int unsigned AW   = 6;
    localparam int unsigned AW_W = 2;

    typedef struct packed {
        logic [31:0]   instr;
        logic [AW+1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_WIDTH(AW))   bus ();
    instr_encoder_if #(.ADDR_WIDTH(AW_W)) bus_w ();

    logic          err;
    logic [7:0]    err_count;
    logic [AW:0]   emit_count;
    logic          err_w;
    logic [7:0]    err_count_w;
    logic [AW_W:0] emit_count_w;

    instr_encoder #(.ADDR_WIDTH(AW), .ERR_CNT_WIDTH(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .err        (err),
        .err_count  (err_count),
        .emit_count (emit_count)
    );

    instr_encoder #(.ADDR_WIDTH(AW_W), .ERR_CNT_WIDTH(8)) u_dut_w (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_w),
        .err        (err_w),
        .err_count  (err_count_w),
        .emit_count (emit_count_w)
    );

    exp_t          sb_q[$];
    logic [AW+1:0] next_addr;
    logic [31:0]   req_exp;
    logic          req_legal;
    bit            accepted;
    int            n_asserts = 0;
    int            n_fails   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample handshakes mid-cycle, then advance to just after the next rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("out_instr", bus.out_instr, e.instr);
                check("out_addr", 32'(bus.out_addr), 32'(e.addr));
            end
        end
        accepted = bus.in_valid && bus.in_ready;
        if (accepted && req_legal) begin
            e.instr = req_exp;
            e.addr  = next_addr;
            sb_q.push_back(e);
            next_addr = next_addr + (AW+2)'(4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                           input logic [31:0] imm, input logic [31:0] exp, input logic legal);
        bus.in_class    = cls;
        bus.in_rd       = rd;
        bus.in_rs1      = rs1;
        bus.in_rs2      = rs2;
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7;
        bus.in_imm      = imm;
        req_exp         = exp;
        req_legal       = legal;
    endtask

    task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm, input logic [31:0] exp, input logic legal);
        set_req(cls, rd, rs1, rs2, f3, f7, imm, exp, legal);
        bus.in_valid = 1'b1;
        accepted     = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) tick();
        bus.in_valid = 1'b0;
        check("accept_timeout", 32'(accepted), 32'd1);
        check("err_pulse", 32'(err), 32'(!legal));
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0 && !bus.out_valid) break;
            tick();
        end
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        next_addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        next_addr = '0;
        accepted  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        set_req(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        bus_w.in_valid = 1'b0; bus_w.out_ready = 1'b0; bus_w.in_class = 3'd4;
        bus_w.in_rd = 5'd1; bus_w.in_rs1 = 5'd0; bus_w.in_rs2 = 5'd0;
        bus_w.in_funct3 = 3'd0; bus_w.in_funct7b5 = 1'b0; bus_w.in_imm = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_addr", 32'(bus.out_addr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_emit_count", 32'(emit_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // lw, visible one cycle after acceptance
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8, 32'h0081_2283, 1'b1);
        check("lw_out_valid", 32'(bus.out_valid), 32'd1);
        check("lw_out_instr", bus.out_instr, 32'h0081_2283);
        check("lw_out_addr", 32'(bus.out_addr), 32'd0);
        drain();
        check("emit_count_1", 32'(emit_count), 32'd1);

        // sw then R sub from a fresh address
        do_reset();
        send(3'd1, 5'd0, 5'd2, 5'd6, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE61_2E23, 1'b1);
        send(3'd2, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'd0, 32'h4031_00B3, 1'b1);
        check("sw_head_stable", bus.out_instr, 32'hFE61_2E23);
        drain();

        // beq, jal, srai with the consumer always ready
        bus.out_ready = 1'b1;
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 1'b1);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 32'h0010_00EF, 1'b1);
        send(3'd4, 5'd3, 5'd3, 5'd0, 3'd5, 1'b1, 32'd4, 32'h4041_D193, 1'b1);
        drain();
        check("emit_count_5", 32'(emit_count), 32'd5);

        // Backpressure: third request stalls until the consumer releases
        do_reset();
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8, 32'h0081_2283, 1'b1);
        send(3'd1, 5'd0, 5'd2, 5'd6, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE61_2E23, 1'b1);
        set_req(3'd2, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'd0, 32'h4031_00B3, 1'b1);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_in_ready", 32'(bus.in_ready), 32'd0);
            check("full_head_stable", bus.out_instr, 32'h0081_2283);
            check("full_addr_stable", 32'(bus.out_addr), 32'd0);
        end
        bus.out_ready = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) tick();
        bus.in_valid = 1'b0;
        check("release_accept", 32'(accepted), 32'd1);
        drain();

        // Rejected requests
        send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("err_count_1", 32'(err_count), 32'd1);
        tick();
        check("err_one_cycle", 32'(err), 32'd0);
        check("illegal_no_out", 32'(bus.out_valid), 32'd0);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3, 32'd0, 1'b0);
        check("err_count_2", 32'(err_count), 32'd2);
        send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 32'd0, 1'b0);
        check("err_count_3", 32'(err_count), 32'd3);
        send(3'd4, 5'd1, 5'd1, 5'd0, 3'd5, 1'b1, 32'd32, 32'd0, 1'b0);
        send(3'd1, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_F7FF, 32'd0, 1'b0);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 32'd0, 1'b0);
        check("err_count_6", 32'(err_count), 32'd6);
        check("illegal_no_out2", 32'(bus.out_valid), 32'd0);

        // Immediate range edges that are still legal
        send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2047, 32'h7FF0_2083, 1'b1);
        send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFF_F800, 32'h8000_2083, 1'b1);
        drain();
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFF0_0000, 32'h8000_00EF, 1'b1);
        send(3'd4, 5'd1, 5'd1, 5'd0, 3'd1, 1'b0, 32'd31, 32'h01F0_9093, 1'b1);
        drain();

        // err_count saturation
        for (int i = 0; i < 255; i++) begin
            send(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        end
        check("err_count_sat", 32'(err_count), 32'd255);

        // Reset with two words buffered
        send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8, 32'h0081_2283, 1'b1);
        send(3'd1, 5'd0, 5'd2, 5'd6, 3'd0, 1'b0, 32'hFFFF_FFFC, 32'hFE61_2E23, 1'b1);
        check("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_err_count", 32'(err_count), 32'd0);
        check("midrst_emit_count", 32'(emit_count), 32'd0);
        do_reset();
        send(3'd2, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 32'd0, 32'h4031_00B3, 1'b1);
        check("post_rst_addr", 32'(bus.out_addr), 32'd0);
        check("post_rst_instr", bus.out_instr, 32'h4031_00B3);
        drain();

        // Address wrap and emit_count saturation on the 2-bit instance
        for (int k = 0; k < 9; k++) begin
            bus_w.in_imm   = 32'(k);
            bus_w.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus_w.in_valid = 1'b0;
            check("wrap_out_valid", 32'(bus_w.out_valid), 32'd1);
            check("wrap_out_instr", bus_w.out_instr, {12'(k), 5'd0, 3'd0, 5'd1, 7'b0010011});
            check("wrap_out_addr", 32'(bus_w.out_addr), 32'((4 * k) % 16));
            bus_w.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus_w.out_ready = 1'b0;
        end
        check("wrap_emit_sat", 32'(emit_count_w), 32'd7);
        check("wrap_err", 32'(err_w), 32'd0);
        check("wrap_err_count", 32'(err_count_w), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder, the inverse of the main decoder.
- Accepts field-level requests (class, register indices, funct bits, immediate) over a valid/ready handshake and assembles 32-bit instruction words.
- Words are emitted through a 2-entry output FIFO, each tagged with a sequential byte address.
- Used by the boot/test-program loader to fill instruction memory and to generate decoder stimulus.

Parameters:
ADDR_WIDTH, 6, instruction-memory word-address width; out_addr is ADDR_WIDTH+2 bits wide.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_class  input  3  0=lw 1=sw 2=R 3=beq 4=I-ALU 5=jal, 6/7 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3; used by R and I only
in_funct7b5  input  1  funct7 bit 5 (sub/sra/srai)
in_imm  input  32  signed immediate, byte offset for beq/jal
out_valid  output  1  encoded word available
out_ready  input  1  consumer accepts when out_valid && out_ready
out_instr  output  32  encoded instruction
out_addr  output  ADDR_WIDTH+2  byte address of out_instr, word aligned
err  output  1  one-cycle pulse: request rejected
err_count  output  ERR_CNT_WIDTH  saturating count of rejected requests
emit_count  output  ADDR_WIDTH+1  words emitted since reset, saturating

Behaviour:
Reset values (async assert, sync deassert handled upstream):
- FIFO empty, out_valid=0, out_instr=0, out_addr=0.
- err=0, err_count=0, emit_count=0, in_ready=1.

Input handshake:
- in_ready = (FIFO occupancy < 2). It is registered-state only, with no combinational path from out_ready.
- Full FIFO with a simultaneous pop does not admit a push that cycle.

Encoding (combinational on the accepted request, pushed at the accepting edge):
- lw: imm[11:0] | rs1 | 010 | rd | 0000011
- sw: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011
- R: {0, f7b5, 00000} | rs2 | rs1 | f3 | rd | 0110011
- beq: imm[12] | imm[10:5] | rs2 | rs1 | 000 | imm[4:1] | imm[11] | 1100011
- I: imm[11:0] | rs1 | f3 | rd | 0010011
  - For f3=001 or 101: bits[31:25] = {0, f7b5, 00000}, bits[24:20] = imm[4:0].
- jal: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111
- Unused fields for a class are ignored.

Rejection (request is consumed, not pushed; err pulses the cycle after acceptance):
- in_class is 6 or 7.
- beq/jal with imm[0]=1.
- Immediate out of signed range:
  - lw/sw/I: 12 bits.
  - beq: 13 bits.
  - jal: 21 bits.
  - Shift-I: imm outside 0..31.
- err_count increments per rejection and saturates at all-ones.

Output:
- Latency: a request accepted at edge N appears at out_valid after edge N (FIFO registered head), if the FIFO was empty.
- Order is preserved; out_instr/out_addr are stable while out_valid && !out_ready.
- On each pop: out_addr += 4, wrapping modulo 2^(ADDR_WIDTH+2) to 0; emit_count increments, saturating.
- Push and pop in the same cycle with occupancy 1 keeps occupancy 1, and the new word becomes head next cycle.

Reset mid-operation:
- All FIFO contents are discarded.
- Address restarts at 0.

Test Plan:
- Reset then request lw rd=5 rs1=2 imm=8 -> out_instr=0x00812283, out_addr=0 one cycle after acceptance.
- sw rs2=6 rs1=2 imm=-4, then R sub rd=1 rs1=2 rs2=3 f3=0 f7b5=1 -> 0xFE612E23 @0x0, then 0x403100B3 @0x4.
- beq rs1=1 rs2=2 imm=-8 -> 0xFE208CE3.
- jal rd=1 imm=2048 -> 0x001000EF.
- srai rd=3 rs1=3 imm=4 f3=5 f7b5=1 -> 0x4041D193.
- Hold out_ready=0 and present 3 requests -> in_ready drops after 2 accepts, out_instr stable.
- Release out_ready -> all 3 words emitted in order at 0x0, 0x4, 0x8.
- Illegal requests:
  - class=7 -> err pulse, err_count=1, no output.
  - beq imm=3 -> err_count=2.
  - lw imm=2048 -> err_count=3.
- Wrap: ADDR_WIDTH=2, emit 5 words -> addresses 0x0, 0x4, 0x8, 0xC, 0x0.
- Reset mid-stream: assert rst_n=0 with 2 words buffered -> out_valid=0 immediately, then out_addr=0 on the next word.
